// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-accumulate datapath.
// Contents:
//   mul_acc_state_e  - accumulator sequencer states
//   MUL_N            - default operand width of the upstream multiplier
//   MUL_ACC_W        - default accumulator width
//   MUL_CNT_W        - default width of the product-count field
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } mul_acc_state_e;

   localparam int MUL_N     = 16;
   localparam int MUL_ACC_W = 40;
   localparam int MUL_CNT_W = 8;

endpackage

// File: rtl/mul_accum_acc_add.sv
// acc_add: combinational ACC_W-bit unsigned adder for the accumulator.
// Ports:
//   a_i      in   ACC_W  current accumulator value
//   b_i      in   ACC_W  zero-extended product
//   sum_o    out  ACC_W  next accumulator value
//   carry_o  out  1      carry out of bit ACC_W-1
// Build option: MUL_ACCUM_SAT_EN selects saturating sum (all-ones on carry);
// when undefined the sum wraps modulo 2**ACC_W.
module acc_add #(
   parameter int ACC_W = 40
) (
   input  logic [ACC_W-1:0] a_i,
   input  logic [ACC_W-1:0] b_i,
   output logic [ACC_W-1:0] sum_o,
   output logic             carry_o
);

   logic [ACC_W:0] raw_sum;

   always_comb begin
      raw_sum = {1'b0, a_i} + {1'b0, b_i};
      carry_o = raw_sum[ACC_W];
`ifdef MUL_ACCUM_SAT_EN
      // Once saturated, any further nonzero add carries again and zero adds
      // leave all-ones in place, so the value sticks for the sequence.
      sum_o = carry_o ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
      sum_o = raw_sum[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/mul_accum.sv
// mul_accum: sums a programmed number of 2N-bit products into an ACC_W-bit
// accumulator and hands the result to writeback.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start_i, len_i   begin a sequence of len_i products (len_i=0 -> empty)
//   prod_i           product, valid/ready with prod_valid_i / prod_ready_o
//   acc_o, ovf_o     result and sticky overflow, valid/ready with
//                    acc_valid_o / acc_ready_i
//   busy_o           sequencer not idle
// Build option: MUL_ACCUM_SAT_EN (see acc_add) saturates instead of wrapping.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start_i
//   ACCUM | accepting products, one per cycle, until len reached
//   DONE  | result held on acc_o until acc_ready_i
module mul_accum
   import mul_pkg::*;
#(
   parameter int N     = MUL_N,
   parameter int ACC_W = MUL_ACC_W,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic [2*N-1:0]   prod_i,
   input  logic             prod_valid_i,
   output logic             prod_ready_o,
   output logic [ACC_W-1:0] acc_o,
   output logic             acc_valid_o,
   input  logic             acc_ready_i,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mul_acc_state_e   state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             prod_ready_q, prod_ready_d;
   logic             acc_valid_q, acc_valid_d;
   logic             busy_q, busy_d;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic             start_ok;
   logic             prod_hs;

   always_comb begin
      prod_ext           = '0;
      prod_ext[2*N-1:0]  = prod_i;
   end

   acc_add #(
      .ACC_W (ACC_W)
   ) u_acc_add (
      .a_i     (acc_q),
      .b_i     (prod_ext),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   assign prod_hs = prod_valid_i && prod_ready_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      start_ok = 1'b0;

      unique case (state_q)
         IDLE: start_ok = start_i;
         ACCUM: begin
            if (prod_hs) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_carry;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == len_q - CNT_ONE) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (acc_ready_i) begin
               state_d  = IDLE;
               start_ok = start_i;
            end
         end
         default: state_d = IDLE;
      endcase

      // A consumed result can be followed by a new start in the same cycle.
      if (start_ok) begin
         len_d   = len_i;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
         state_d = (len_i != '0) ? ACCUM : DONE;
      end

      prod_ready_d = (state_d == ACCUM);
      acc_valid_d  = (state_d == DONE);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         cnt_q        <= '0;
         len_q        <= '0;
         prod_ready_q <= 1'b0;
         acc_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         prod_ready_q <= prod_ready_d;
         acc_valid_q  <= acc_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign prod_ready_o = prod_ready_q;
   assign acc_o        = acc_q;
   assign acc_valid_o  = acc_valid_q;
   assign ovf_o        = ovf_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_mul_accum.sv
module tb_mul_accum;

   localparam int N     = 16;
   localparam int ACC_W = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic [CNT_W-1:0] len_i;
   logic [2*N-1:0]   prod_i;
   logic             prod_valid_i;
   logic             prod_ready_o;
   logic [ACC_W-1:0] acc_o;
   logic             acc_valid_o;
   logic             acc_ready_i;
   logic             ovf_o;
   logic             busy_o;

   int n_cmp = 0;
   int n_err = 0;

   mul_accum #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .len_i        (len_i),
      .prod_i       (prod_i),
      .prod_valid_i (prod_valid_i),
      .prod_ready_o (prod_ready_o),
      .acc_o        (acc_o),
      .acc_valid_o  (acc_valid_o),
      .acc_ready_i  (acc_ready_i),
      .ovf_o        (ovf_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected result from the true (unbounded) sum of the sequence.
   function automatic logic [ACC_W:0] ref_result(input longint unsigned total);
      logic [ACC_W-1:0] r;
      logic             o;
      o = (total >= (64'd1 << ACC_W));
`ifdef MUL_ACCUM_SAT_EN
      r = o ? {ACC_W{1'b1}} : total[ACC_W-1:0];
`else
      r = total[ACC_W-1:0];
`endif
      return {o, r};
   endfunction

   // Called at a negedge with the DUT idle.
   task automatic start_seq(input int len);
      start_i = 1'b1;
      len_i   = CNT_W'(len);
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1);
      chk("prod_ready_after_start", prod_ready_o, (len != 0));
      chk("acc_valid_after_start", acc_valid_o, (len == 0));
   endtask

   // Idle gap cycles (with stray start pulses), then one product handshake.
   task automatic feed(input logic [31:0] p, input int gap);
      for (int g = 0; g < gap; g++) begin
         prod_valid_i = 1'b0;
         prod_i       = $urandom;
         start_i      = 1'b1;
         len_i        = '0;
         @(negedge clk);
      end
      start_i      = 1'b0;
      prod_valid_i = 1'b1;
      prod_i       = p;
      chk("prod_ready_in_accum", prod_ready_o, 1);
      chk("acc_valid_in_accum", acc_valid_o, 0);
      @(negedge clk);
      prod_valid_i = 1'b0;
      prod_i       = $urandom;
   endtask

   // Checks the DONE result, holds it for 'hold' cycles, then consumes it,
   // optionally starting the next sequence of length nl in the same cycle.
   task automatic finish_seq(input logic [31:0] ea, input bit eo, input int hold,
                             input bit btb, input int nl);
      chk("acc_valid_done", acc_valid_o, 1);
      chk("acc_done", acc_o, ea);
      chk("ovf_done", ovf_o, eo);
      chk("prod_ready_done", prod_ready_o, 0);
      chk("busy_done", busy_o, 1);
      for (int h = 0; h < hold; h++) begin
         acc_ready_i  = 1'b0;
         prod_valid_i = h[0];
         prod_i       = 32'h0000_1234;
         start_i      = ~h[0];
         len_i        = 8'd3;
         @(negedge clk);
         chk("acc_hold", acc_o, ea);
         chk("ovf_hold", ovf_o, eo);
         chk("acc_valid_hold", acc_valid_o, 1);
         chk("prod_ready_hold", prod_ready_o, 0);
      end
      prod_valid_i = 1'b0;
      acc_ready_i  = 1'b1;
      start_i      = btb;
      len_i        = CNT_W'(nl);
      @(negedge clk);
      acc_ready_i  = 1'b0;
      start_i      = 1'b0;
      if (btb) begin
         chk("btb_acc_cleared", acc_o, 0);
         chk("btb_ovf_cleared", ovf_o, 0);
         chk("btb_acc_valid", acc_valid_o, (nl == 0));
         chk("btb_prod_ready", prod_ready_o, (nl != 0));
         chk("btb_busy", busy_o, 1);
      end else begin
         chk("acc_valid_after_consume", acc_valid_o, 0);
         chk("busy_after_consume", busy_o, 0);
      end
   endtask

   typedef struct {
      int               len;
      logic [3:0][31:0] p;
      int               gap;
      int               hold;
      logic [31:0]      exp_acc;
      bit               exp_ovf;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs[NV];

   initial begin
      logic [ACC_W:0]    r;
      longint unsigned   total;
      int                len, nl;
      bit                in_seq, btb;
      logic [31:0]       p;

      vecs[0] = '{len: 3, p: {32'd0, 32'd30, 32'd20, 32'd10}, gap: 0, hold: 5,
                  exp_acc: 32'd60, exp_ovf: 1'b0};
      vecs[1] = '{len: 0, p: '0, gap: 0, hold: 3, exp_acc: 32'd0, exp_ovf: 1'b0};
      vecs[2] = '{len: 2, p: {32'd0, 32'd0, 32'd9, 32'd5}, gap: 3, hold: 1,
                  exp_acc: 32'd14, exp_ovf: 1'b0};
`ifdef MUL_ACCUM_SAT_EN
      vecs[3] = '{len: 2, p: {32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE}, gap: 0, hold: 2,
                  exp_acc: 32'hFFFF_FFFF, exp_ovf: 1'b1};
      vecs[5] = '{len: 4, p: {32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF}, gap: 1, hold: 1,
                  exp_acc: 32'hFFFF_FFFF, exp_ovf: 1'b1};
`else
      vecs[3] = '{len: 2, p: {32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE}, gap: 0, hold: 2,
                  exp_acc: 32'h0000_0001, exp_ovf: 1'b1};
      vecs[5] = '{len: 4, p: {32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF}, gap: 1, hold: 1,
                  exp_acc: 32'd5, exp_ovf: 1'b1};
`endif
      vecs[4] = '{len: 1, p: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, gap: 0, hold: 0,
                  exp_acc: 32'hFFFF_FFFF, exp_ovf: 1'b0};

      rst = 1'b1; start_i = 1'b0; len_i = '0; prod_i = '0;
      prod_valid_i = 1'b0; acc_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_acc", acc_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_prod_ready", prod_ready_o, 0);
      chk("rst_acc_valid", acc_valid_o, 0);
      chk("rst_busy", busy_o, 0);

      // Products offered while idle must not be taken.
      prod_valid_i = 1'b1; prod_i = 32'd99;
      @(negedge clk);
      prod_valid_i = 1'b0;
      chk("idle_prod_ready", prod_ready_o, 0);
      chk("idle_acc", acc_o, 0);

      for (int i = 0; i < NV; i++) begin
         start_seq(vecs[i].len);
         for (int j = 0; j < vecs[i].len; j++) feed(vecs[i].p[j], vecs[i].gap);
         finish_seq(vecs[i].exp_acc, vecs[i].exp_ovf, vecs[i].hold, 1'b0, 0);
      end

      // Back-to-back: 1+2, then a new 4+5+6 started while consuming.
      start_seq(2);
      feed(32'd1, 0);
      feed(32'd2, 0);
      finish_seq(32'd3, 1'b0, 2, 1'b1, 3);
      feed(32'd4, 0);
      feed(32'd5, 0);
      feed(32'd6, 0);
      finish_seq(32'd15, 1'b0, 0, 1'b0, 0);

      // Reset mid-sequence with a product in flight.
      start_seq(4);
      feed(32'd1, 0);
      feed(32'd2, 0);
      prod_valid_i = 1'b1; prod_i = 32'd3; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; prod_valid_i = 1'b0;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_acc", acc_o, 0);
      chk("midrst_ovf", ovf_o, 0);
      chk("midrst_prod_ready", prod_ready_o, 0);
      chk("midrst_acc_valid", acc_valid_o, 0);
      start_seq(1);
      feed(32'd7, 0);
      finish_seq(32'd7, 1'b0, 1, 1'b0, 0);

      // Randomized sequences against the arithmetic reference.
      in_seq = 1'b0;
      len    = 0;
      for (int k = 0; k < 30; k++) begin
         if (!in_seq) begin
            len = $urandom_range(0, 6);
            start_seq(len);
         end
         total = 0;
         for (int j = 0; j < len; j++) begin
            p = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 1000));
            total += longint'(p);
            feed(p, $urandom_range(0, 2));
         end
         r   = ref_result(total);
         btb = (k != 29) && ($urandom_range(0, 1) == 1);
         nl  = $urandom_range(0, 6);
         finish_seq(r[ACC_W-1:0], r[ACC_W], $urandom_range(0, 3), btb, nl);
         in_seq = btb;
         len    = nl;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_accum.md
Name: mul_accum

Overview:
- Downstream consumer of the combinational unsigned multiplier in the CPU execute path.
- Accepts a stream of 2N-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the final sum to writeback through a second valid/ready handshake.
- Used for dot-product / MAC instructions; holds state across cycles so the multiplier itself can stay purely combinational.

Parameters:
N, 16, operand width of the upstream multiplier; product width is 2*N
ACC_W, 40, accumulator width; must be >= 2*N
CNT_W, 8, width of the product-count field; max sequence length 2**CNT_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start_i  input  1  begin a new accumulation; sampled only when accepted (see Behaviour)
len_i  input  CNT_W  number of products to accumulate; latched with accepted start_i
prod_i  input  2*N  unsigned product from the multiplier
prod_valid_i  input  1  prod_i is valid this cycle
prod_ready_o  output  1  block can accept a product this cycle
acc_o  output  ACC_W  accumulated sum
acc_valid_o  output  1  acc_o holds a completed result
acc_ready_i  input  1  writeback consumes acc_o this cycle
ovf_o  output  1  sticky overflow for the current/last sequence; valid with acc_valid_o
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous; state=IDLE, acc_o=0, ovf_o=0, count=0, prod_ready_o=0, acc_valid_o=0, busy_o=0. Reset mid-sequence discards all partial state; an in-flight product is not consumed.
- States:
  - IDLE: start_i=1 latches len_i, clears acc and ovf, sets count=0. Next state is ACCUM if len_i != 0; otherwise DONE with acc_o=0.
  - ACCUM: prod_ready_o=1. On prod_valid_i && prod_ready_o: acc <= acc + zero-extend(prod_i); count++. The handshake with count==len-1 moves to DONE.
  - DONE: acc_valid_o=1; acc_o and ovf_o are held stable until acc_ready_i=1. Then go to IDLE, or accept start_i in that same cycle (see below).
- Latency: acc_valid_o rises the cycle after the last product handshake. Throughput is one product per cycle with no bubbles.
- Back-to-back sequences: start_i and acc_ready_i both high in DONE:
  - the result is consumed;
  - the new start is accepted, acc is cleared and len is latched;
  - next state follows the IDLE rules.
- start_i is ignored in ACCUM, and in DONE while acc_ready_i=0.
- prod_valid_i outside ACCUM is ignored; prod_ready_o is 0 there.
- Overflow (default): sum wraps modulo 2**ACC_W. ovf_o is set on any carry out of bit ACC_W-1, stays sticky until the next accepted start, and does not stop accumulation.
- Arithmetic: unsigned only. The product is zero-extended to ACC_W bits.

Optional Feature:
- Macro: MUL_ACCUM_SAT_EN.
- Defined: on carry out, acc saturates to all-ones (2**ACC_W-1) and stays there for the rest of the sequence. ovf_o is still set.
- Undefined: wrap-around as above. No saturation logic is synthesised.

Decomposition:
- Shared package mul_pkg:
  - state enum mul_acc_state_e {IDLE, ACCUM, DONE};
  - default width constants MUL_N=16, MUL_ACC_W=40, MUL_CNT_W=8.
- One natural sub-module: acc_add, a combinational ACC_W adder.
  - Outputs: sum and carry.
  - Saturation mux sits inside it, guarded by MUL_ACCUM_SAT_EN.

Test Plan:
- Basic sum: start with len=3; products 10, 20, 30 on consecutive cycles → acc_valid_o one cycle after the third handshake, acc_o=60, ovf_o=0.
- Empty sequence: start with len=0 → DONE next cycle, acc_o=0, acc_valid_o=1, prod_ready_o stays 0.
- Backpressure: hold acc_ready_i=0 for 5 cycles in DONE with prod_valid_i toggling → acc_o and ovf_o stable, prod_ready_o=0, no extra accumulation. Back-to-back start with acc_ready_i=1 → acc cleared and new sequence runs.
- Overflow with ACC_W=32, N=16: len=2, products 0xFFFF_FFFE and 0x3:
  - default → acc_o=0x1, ovf_o=1;
  - with MUL_ACCUM_SAT_EN → acc_o=0xFFFF_FFFF, ovf_o=1.
- Reset mid-operation: len=4, assert rst after 2 products → next cycle state IDLE, acc_o=0, busy_o=0. Then a fresh len=1 sequence with product 7 → acc_o=7.
- Stalled input: len=2, prod_valid_i gaps of 3 cycles between products 5 and 9 → acc_o=14. start_i pulses during ACCUM are ignored.
